// File: rtl/wb_initiator_pkg.sv
// Shared Wishbone map and initiator definitions: region/field layout, FSM encoding, address helpers.
// Latency: none (declarations only).
// Backpressure: not applicable.
package wb_initiator_pkg;

   // Region field [31:30] of every bus address
   localparam logic [1:0] REGION_PROG    = 2'b00;
   localparam logic [1:0] REGION_PADS    = 2'b01;
   localparam logic [1:0] REGION_DEBUG   = 2'b10;
   localparam logic [1:0] REGION_ENTROPY = 2'b11;

   // Every cycle is a full-word access
   localparam logic [3:0] SEL_ALL = 4'hF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      RESP = 2'd2
   } state_t;

   // prog: core select [10:8], pc [7:0]
   function automatic logic [31:0] prog_adr(input logic [2:0] core, input logic [7:0] pc);
      return {REGION_PROG, 19'd0, core, pc};
   endfunction

   // pads: word select [0]
   function automatic logic [31:0] pads_adr(input logic word);
      return {REGION_PADS, 29'd0, word};
   endfunction

   // debug: core select [7:5], register [4:0]
   function automatic logic [31:0] debug_adr(input logic [2:0] core, input logic [4:0] regi);
      return {REGION_DEBUG, 22'd0, core, regi};
   endfunction

   function automatic logic [31:0] entropy_adr();
      return {REGION_ENTROPY, 30'd0};
   endfunction

endpackage

// File: rtl/wb_initiator_if.sv
// Command/response handshake plus Wishbone master signals of the initiator, bundled as one port.
// Latency: none (wiring only).
// Backpressure: valid/ready on req and rsp; Wishbone ack on the bus side.
interface wb_initiator_if #(
   parameter int WB_WIDTH = 32
);
   logic                req_valid;
   logic                req_ready;
   logic                req_we;
   logic [WB_WIDTH-1:0] req_adr;
   logic [WB_WIDTH-1:0] req_dat;

   logic                rsp_valid;
   logic                rsp_ready;
   logic [WB_WIDTH-1:0] rsp_dat;
   logic                rsp_err;

   logic                wbm_cyc_o;
   logic                wbm_stb_o;
   logic                wbm_we_o;
   logic [3:0]          wbm_sel_o;
   logic [WB_WIDTH-1:0] wbm_adr_o;
   logic [WB_WIDTH-1:0] wbm_dat_o;
   logic                wbm_ack_i;
   logic [WB_WIDTH-1:0] wbm_dat_i;

   // Initiator side
   modport master (
      input  req_valid, req_we, req_adr, req_dat,
      output req_ready,
      output rsp_valid, rsp_dat, rsp_err,
      input  rsp_ready,
      output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
      input  wbm_ack_i, wbm_dat_i
   );

   // Command source, response sink and bus responder side
   modport slave (
      output req_valid, req_we, req_adr, req_dat,
      input  req_ready,
      input  rsp_valid, rsp_dat, rsp_err,
      output rsp_ready,
      input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
      output wbm_ack_i, wbm_dat_i
   );
endinterface

// File: rtl/wb_timeout_counter.sv
// Bus-cycle wait counter with synchronous clear, count enable and terminal-count flag.
// Latency: tc reflects the registered count (1 cycle after the enabling edge).
// Backpressure: none; en simply stalls the count.
module wb_timeout_counter #(
   parameter int CNT_WIDTH      = 8,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic tc
);
   logic [CNT_WIDTH-1:0] cnt_q;

   // Count cycles spent waiting; clear wins over enable
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (clr) begin
         cnt_q <= '0;
      end else if (en) begin
         cnt_q <= cnt_q + CNT_WIDTH'(1);
      end
   end

   assign tc = (cnt_q == CNT_WIDTH'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/wb_initiator.sv
// Wishbone classic-cycle initiator: one bus cycle per accepted command, result returned on a response port.
// Latency: bus driven from the accept edge; response registered on the ack edge or after TIMEOUT_CYCLES bus cycles.
// Backpressure: req_ready only in IDLE; response held until rsp_ready, next command accepted the cycle after.
module wb_initiator
   import wb_initiator_pkg::*;
#(
   parameter int WB_WIDTH       = 32,
   parameter int TIMEOUT_CYCLES = 16,
   parameter int CNT_WIDTH      = 8
) (
   input logic            clk,
   input logic            rst_n,
   wb_initiator_if.master bus
);
   state_t              state_q, state_d;
   logic                cyc_q, cyc_d;
   logic                we_q, we_d;
   logic [3:0]          sel_q, sel_d;
   logic [WB_WIDTH-1:0] adr_q, adr_d;
   logic [WB_WIDTH-1:0] dat_q, dat_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic [WB_WIDTH-1:0] rsp_dat_q, rsp_dat_d;
   logic                rsp_err_q, rsp_err_d;

   logic                accept;
   logic                cnt_en;
   logic                cnt_tc;

   assign accept = bus.req_valid && (state_q == IDLE);
   assign cnt_en = (state_q == BUS) && !bus.wbm_ack_i;

   wb_timeout_counter #(
      .CNT_WIDTH      (CNT_WIDTH),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (accept),
      .en    (cnt_en),
      .tc    (cnt_tc)
   );

   // Next-state and next-output values; everything holds unless a transition says otherwise
   always_comb begin
      state_d     = state_q;
      cyc_d       = cyc_q;
      we_d        = we_q;
      sel_d       = sel_q;
      adr_d       = adr_q;
      dat_d       = dat_q;
      rsp_valid_d = rsp_valid_q;
      rsp_dat_d   = rsp_dat_q;
      rsp_err_d   = rsp_err_q;
      case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               state_d = BUS;
               cyc_d   = 1'b1;
               we_d    = bus.req_we;
               sel_d   = SEL_ALL;
               adr_d   = bus.req_adr;
               dat_d   = bus.req_dat;
            end
         end
         BUS: begin
            // Ack is checked first so an ack on the last allowed cycle still completes normally
            if (bus.wbm_ack_i || cnt_tc) begin
               state_d     = RESP;
               cyc_d       = 1'b0;
               we_d        = 1'b0;
               sel_d       = '0;
               adr_d       = '0;
               dat_d       = '0;
               rsp_valid_d = 1'b1;
               rsp_err_d   = !bus.wbm_ack_i;
               rsp_dat_d   = (bus.wbm_ack_i && !we_q) ? bus.wbm_dat_i : '0;
            end
         end
         RESP: begin
            if (bus.rsp_ready) begin
               state_d     = IDLE;
               rsp_valid_d = 1'b0;
               rsp_dat_d   = '0;
               rsp_err_d   = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and all bus/response registers; reset aborts any cycle in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cyc_q       <= 1'b0;
         we_q        <= 1'b0;
         sel_q       <= '0;
         adr_q       <= '0;
         dat_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_dat_q   <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cyc_q       <= cyc_d;
         we_q        <= we_d;
         sel_q       <= sel_d;
         adr_q       <= adr_d;
         dat_q       <= dat_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_dat_q   <= rsp_dat_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign bus.req_ready = (state_q == IDLE);
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_dat   = rsp_dat_q;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.wbm_cyc_o = cyc_q;
   assign bus.wbm_stb_o = cyc_q;
   assign bus.wbm_we_o  = we_q;
   assign bus.wbm_sel_o = sel_q;
   assign bus.wbm_adr_o = adr_q;
   assign bus.wbm_dat_o = dat_q;
endmodule

// File: doc/wb_initiator.md
Name: wb_initiator

Overview:
- Wishbone classic-cycle initiator that drives the same bus the chip's Wishbone responder (prog/pads/debug/entropy mux) answers on.
- Accepts single read/write commands over a valid/ready request port and runs exactly one bus cycle per command.
- Returns the read data or a timeout error over a valid/ready response port.
- Used by on-chip loaders and self-test sequencers to program cores, set pads and read debug and entropy words without the management SoC.

Parameters:
- WB_WIDTH, 32, Wishbone address and data width.
- TIMEOUT_CYCLES, 16, maximum cycles to wait for ack before the cycle is aborted (legal range 2..255).
- CNT_WIDTH, 8, width of the timeout counter (must hold TIMEOUT_CYCLES).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  command present.
- req_ready  out  1  initiator can accept a command.
- req_we  in  1  1 = write, 0 = read.
- req_adr  in  WB_WIDTH  bus address.
- req_dat  in  WB_WIDTH  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes the response.
- rsp_dat  out  WB_WIDTH  read data (0 for writes and errors).
- rsp_err  out  1  1 = timed out.
- wbm_cyc_o  out  1  bus cycle.
- wbm_stb_o  out  1  strobe.
- wbm_we_o  out  1  write enable.
- wbm_sel_o  out  4  byte select, always 4'b1111 during a cycle.
- wbm_adr_o  out  WB_WIDTH  address.
- wbm_dat_o  out  WB_WIDTH  write data.
- wbm_ack_i  in  1  responder acknowledge.
- wbm_dat_i  in  WB_WIDTH  responder read data.

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs 0 except req_ready=1. Timeout counter 0.
- Reset mid-cycle: cyc/stb drop immediately, no response is produced, and the latched command is discarded.
- All bus outputs are registered. No combinational path exists from wbm_ack_i to any output.
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready, latch we/adr/dat into the bus registers, raise cyc=stb=1 and sel=4'hF on that edge, clear the counter, go to BUS.
  - Latency: command accepted at edge N, bus active from N, ack sampled from edge N+1 onward.
- BUS:
  - req_ready=0.
  - The counter increments each cycle without ack.
  - If wbm_ack_i=1: drop cyc/stb/we/sel, set rsp_dat = we ? 0 : wbm_dat_i, rsp_err=0, rsp_valid=1, go to RESP.
  - Else if counter == TIMEOUT_CYCLES-1: drop the bus, set rsp_dat=0, rsp_err=1, rsp_valid=1, go to RESP.
  - Ack and the timeout on the same cycle: ack wins and the response is normal.
  - Minimum command-to-response time is 2 cycles: rsp_valid is high at edge N+2 with a zero-wait responder.
- RESP:
  - rsp_valid stays 1 and rsp_dat/rsp_err are held stable until rsp_ready=1.
  - On that handshake, clear rsp_valid, rsp_dat and rsp_err, go to IDLE.
  - req_ready goes high only after the transition, so there is no back-to-back overlap.
  - Throughput is at most one command per 3 cycles.
- wbm_ack_i outside BUS is ignored and causes no state change.
- wbm_adr_o/wbm_dat_o/wbm_we_o are held constant for the whole cycle and return to 0 when cyc drops.
- req_* inputs are ignored while req_ready=0.

Decomposition:
- Shared header (wb_map defines) holds the bus address map constants:
  - region field [31:30]: 00 prog, 01 pads, 10 debug, 11 entropy.
  - prog: core select [10:8], pc [7:0].
  - pads: word select [0].
  - debug: core select [7:5], register [4:0].
- The same header holds the state encodings IDLE=2'd0, BUS=2'd1, RESP=2'd2.
- One natural sub-module: wb_timeout_counter (clear, enable, terminal-count flag at TIMEOUT_CYCLES-1).

Test Plan:
- Prog write, zero-wait:
  - Stimulus: req_we=1, adr=0x000005DB, dat=0xFFFFFFFF; responder acks the first cycle.
  - Response: cyc/stb/we high for 1 cycle with sel=F, adr=0x000005DB, dat=0xFFFFFFFF; rsp_valid at N+2 with rsp_err=0 and rsp_dat=0.
- Debug read with a 3-wait responder:
  - Stimulus: adr=0x8000004A; responder acks on the 4th bus cycle with dat_i=0x0000F0AA.
  - Response: stb high 4 cycles; rsp_dat=0x0000F0AA, rsp_err=0.
- Timeout:
  - Stimulus: adr=0xC0000000 read, responder never acks, TIMEOUT_CYCLES=16.
  - Response: cyc drops after exactly 16 bus cycles; rsp_err=1, rsp_dat=0.
- Response backpressure:
  - Stimulus: hold rsp_ready=0 for 5 cycles after a completed read.
  - Response: rsp_valid/rsp_dat held stable, req_ready=0 throughout; a new req_valid is not accepted until 1 cycle after rsp_ready=1.
- Ack on the timeout cycle plus stray ack:
  - Stimulus: ack arrives exactly on bus cycle 16; then ack=1 while IDLE.
  - Response: the cycle-16 ack gives rsp_err=0 with the data captured; the IDLE ack causes no response and no state change.
- Reset mid-cycle:
  - Stimulus: rst_n=0 asynchronously during BUS.
  - Response: cyc/stb are 0 before the next clock edge; after release, req_ready=1 and no rsp_valid ever appears for the aborted command.
